enemy_patrol: RTL and testbench

Parametrised patrolling enemy for the game-calc object layer. It replaces the fixed-geometry, derived-clock tower enemy with a single-clock block. Configurable spawn point, patrol length, speed, step, and hitbox. It adds stomp kills, a squash animation phase, a despawned state and a respawn request. Its outputs feed the renderer (screen-relative position, enable) and the player logic (death, stomp).

---
 rtl/enemy_pkg.sv | 6 +
 rtl/enemy_patrol_tick_gen.sv | 14 +
 rtl/enemy_patrol.sv | 109 ++++++++++
 tb/tb_enemy_patrol.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// enemy_pkg: state encoding and player hitbox shared by enemy objects
package enemy_pkg;
  typedef enum logic [1:0] {WALK_L, WALK_R, SQUASH, DEAD} state_t;
  localparam int CHAR_W = 12;
  localparam int CHAR_H = 12;
endpackage

// File: rtl/enemy_patrol_tick_gen.sv
// tick_gen: free-running divider emitting a one-cycle tick every DIV cycles
module tick_gen #(
  parameter int DIV = 2_000_000
) (
  input  logic sys_clk,
  input  logic RST,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] r_cnt;
  assign tick = r_cnt == CW'(DIV - 1);
  always_ff @(posedge sys_clk)
    r_cnt <= (RST || tick) ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/enemy_patrol.sv
// enemy_patrol: patrolling enemy with stomp kill, squash phase, despawn and respawn
module enemy_patrol
  import enemy_pkg::*;
#(
  parameter int X_INIT       = 112,
  parameter int Y_INIT       = 366,
  parameter int PATROL_LEN   = 100,
  parameter int STEP         = 1,
  parameter int TICK_DIV     = 2_000_000,
  parameter int EN_W         = 12,
  parameter int EN_H         = 12,
  parameter int STOMP_BAND   = 4,
  parameter int SQUASH_TICKS = 5
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic [9:0] char_X,
  input  logic [9:0] char_Y,
  input  logic       char_falling,
  input  logic [9:0] bg_pos,
  input  logic       respawn,
  output logic [9:0] enemy_x,
  output logic [9:0] enemy_y,
  output logic       death,
  output logic       stomp,
  output logic       squashed,
  output logic       en
);
  localparam int LW = $clog2(PATROL_LEN + 1);
  localparam int SW = $clog2(SQUASH_TICKS + 1);
  localparam logic [LW-1:0] LEG_MAX = LW'(PATROL_LEN - 1);
  localparam logic [SW-1:0] SQ_MAX  = SW'(SQUASH_TICKS - 1);

  if (X_INIT < PATROL_LEN * STEP || PATROL_LEN < 1 || STEP < 1 || STEP > 15 || TICK_DIV < 2 || SQUASH_TICKS < 1)
    begin : g_bad_params
      $error("enemy_patrol: illegal parameter combination");
    end

  state_t        r_state;
  logic [9:0]    r_world_x;
  logic [LW-1:0] r_leg_cnt;
  logic [SW-1:0] r_squash_cnt;
  logic          r_death;
  logic          r_stomp;
  logic          w_tick;
  logic          w_restart;
  logic          w_walking;
  logic          w_overlap;
  logic          w_stomp;
  logic [10:0]   w_px;
  logic [10:0]   w_py;
  logic [10:0]   w_ex;
  logic [10:0]   w_ey;

  assign w_px = {1'b0, char_X};
  assign w_py = {1'b0, char_Y};
  assign w_ex = {1'b0, r_world_x};
  assign w_ey = 11'(Y_INIT);
  // 11-bit compares so boxes near 1023 never wrap into false overlaps
  assign w_overlap = (w_px < w_ex + 11'(EN_W)) && (w_ex < w_px + 11'(CHAR_W)) &&
                     (w_py < w_ey + 11'(EN_H)) && (w_ey < w_py + 11'(CHAR_H));
  assign w_stomp   = w_overlap && char_falling && (w_py + 11'(CHAR_H) <= w_ey + 11'(STOMP_BAND));
  assign w_walking = r_state == WALK_L || r_state == WALK_R;
  assign w_restart = RST || (r_state == DEAD && respawn);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .sys_clk (sys_clk),
    .RST     (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (w_restart) begin
      r_state      <= WALK_L;
      r_world_x    <= 10'(X_INIT);
      r_leg_cnt    <= '0;
      r_squash_cnt <= '0;
      r_death      <= 1'b0;
      r_stomp      <= 1'b0;
    end else begin
      r_stomp <= w_walking && w_stomp;
      r_death <= w_walking && w_overlap && !w_stomp;
      case (r_state)
        WALK_L, WALK_R: begin
          if (w_stomp) begin
            r_state      <= SQUASH;
            r_squash_cnt <= '0;
          end else if (w_tick) begin
            r_world_x <= r_state == WALK_L ? r_world_x - 10'(STEP) : r_world_x + 10'(STEP);
            r_leg_cnt <= r_leg_cnt == LEG_MAX ? '0 : r_leg_cnt + LW'(1);
            if (r_leg_cnt == LEG_MAX) r_state <= r_state == WALK_L ? WALK_R : WALK_L;
          end
        end
        SQUASH: begin
          if (w_tick && r_squash_cnt == SQ_MAX) r_state <= DEAD;
          else if (w_tick) r_squash_cnt <= r_squash_cnt + SW'(1);
        end
        default: ;
      endcase
    end
  end

  assign enemy_x  = r_world_x - bg_pos;
  assign enemy_y  = 10'(Y_INIT);
  assign death    = r_death;
  assign stomp    = r_stomp;
  assign squashed = r_state == SQUASH;
  assign en       = r_state != DEAD;
endmodule

// File: tb/tb_enemy_patrol.sv
// tb_enemy_patrol: directed stimulus with a cycle-stamped expectation queue checked by a monitor
module tb_enemy_patrol;
  localparam int EX = 0, EY = 1, DTH = 2, STP = 3, SQ = 4, EN = 5;

  typedef struct {
    int         cyc;
    int         sig;
    logic [9:0] val;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       RST;
  logic [9:0] char_X;
  logic [9:0] char_Y;
  logic       char_falling;
  logic [9:0] bg_pos;
  logic       respawn;
  logic [9:0] enemy_x;
  logic [9:0] enemy_y;
  logic       death;
  logic       stomp;
  logic       squashed;
  logic       en;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  enemy_patrol #(
    .X_INIT(112), .Y_INIT(366), .PATROL_LEN(3), .STEP(2), .TICK_DIV(4),
    .EN_W(12), .EN_H(12), .STOMP_BAND(4), .SQUASH_TICKS(5)
  ) dut (
    .sys_clk      (sys_clk),
    .RST          (RST),
    .char_X       (char_X),
    .char_Y       (char_Y),
    .char_falling (char_falling),
    .bg_pos       (bg_pos),
    .respawn      (respawn),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .death        (death),
    .stomp        (stomp),
    .squashed     (squashed),
    .en           (en)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [9:0] actual(int s);
    return s == EX ? enemy_x : s == EY ? enemy_y : s == DTH ? {9'd0, death} :
           s == STP ? {9'd0, stomp} : s == SQ ? {9'd0, squashed} : {9'd0, en};
  endfunction

  function automatic string sname(int s);
    return s == EX ? "enemy_x" : s == EY ? "enemy_y" : s == DTH ? "death" :
           s == STP ? "stomp" : s == SQ ? "squashed" : "en";
  endfunction

  always @(negedge sys_clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [9:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      total++;
      if (a !== e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%0d want=%0d", sname(e.sig), e.cyc, a, e.val);
      end
    end
  end

  task automatic chk(int s, int v);
    q.push_back('{cyc, s, 10'(v)});
  endtask

  task automatic step(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int seq[8];
    seq = '{112, 110, 108, 106, 108, 110, 112, 110};
    RST = 1'b1; char_X = 10'd600; char_Y = 10'd0; char_falling = 1'b0;
    bg_pos = 10'd20; respawn = 1'b0;
    step(2);
    chk(EX, 92); chk(EY, 366); chk(DTH, 0); chk(STP, 0); chk(SQ, 0); chk(EN, 1);
    RST = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step(3); chk(EX, seq[k-1] - 20);
      step(1); chk(EX, seq[k] - 20);
    end
    // side contact at x-11, released at x-12 (enemy at 110)
    char_X = 10'd99; char_Y = 10'd366; chk(DTH, 0);
    step(1); chk(DTH, 1);
    char_X = 10'd98;
    step(1); chk(DTH, 0);
    char_X = 10'd600;
    step(1);
    // stomp lands in the tick cycle: no move
    char_X = 10'd99; char_Y = 10'd357; char_falling = 1'b1;
    step(1); chk(STP, 1); chk(DTH, 0); chk(EX, 90); chk(SQ, 1); chk(EN, 1);
    char_Y = 10'd366; char_falling = 1'b0;
    step(1); chk(STP, 0); chk(DTH, 0);
    step(18); chk(SQ, 1); chk(EN, 1); chk(EX, 90);
    step(1); chk(SQ, 0); chk(EN, 0); chk(DTH, 0);
    step(10); chk(EX, 90); chk(EN, 0); chk(DTH, 0);
    char_X = 10'd600; respawn = 1'b1;
    step(1); respawn = 1'b0; chk(EX, 92); chk(EN, 1); chk(SQ, 0);
    respawn = 1'b1;
    step(1); respawn = 1'b0;
    step(2); chk(EX, 92);
    step(1); chk(EX, 90);
    // falling but bottom below the stomp band: contact
    char_X = 10'd99; char_Y = 10'd359; char_falling = 1'b1;
    step(1); chk(DTH, 1); chk(STP, 0); chk(SQ, 0);
    char_X = 10'd600; char_falling = 1'b0;
    step(1); chk(DTH, 0);
    char_X = 10'd99; char_Y = 10'd357; char_falling = 1'b1;
    step(1); chk(STP, 1); chk(SQ, 1);
    char_X = 10'd600; char_falling = 1'b0;
    step(2); chk(SQ, 1);
    RST = 1'b1;
    step(1); chk(EX, 92); chk(DTH, 0); chk(STP, 0); chk(SQ, 0); chk(EN, 1);
    char_X = 10'd101; char_Y = 10'd357; char_falling = 1'b1;
    step(1); chk(STP, 0); chk(SQ, 0); chk(EX, 92);
    RST = 1'b0; char_X = 10'd600; char_falling = 1'b0;
    step(2);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
